pwm_ctrl: RTL and testbench

PWM_CTRL -- requirements
Module: pwm_ctrl

---
 rtl/pwm_ctrl_if.sv | 29 ++
 rtl/pwm_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pwm_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ctrl_if.sv
// Configuration handshake and PWM peripheral command bus for pwm_ctrl.
// The slave side is the controller; the master side is the requester
// together with the PWM timer it commands.
interface pwm_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_top;
  logic [15:0] req_cmp;
  logic [15:0] req_step;
  logic        req_restart;
  logic [15:0] pwm_cnt;
  logic [15:0] pwm_top;
  logic [1:0]  pwm_sel;
  logic [15:0] pwm_d;
  logic        busy;
  logic        done;

  modport master (
    output req_valid, req_top, req_cmp, req_step, req_restart,
    output pwm_cnt, pwm_top,
    input  req_ready, pwm_sel, pwm_d, busy, done
  );

  modport slave (
    input  req_valid, req_top, req_cmp, req_step, req_restart,
    input  pwm_cnt, pwm_top,
    output req_ready, pwm_sel, pwm_d, busy, done
  );
endinterface

// File: rtl/pwm_ctrl.sv
// PWM configuration controller: initialises the PWM timer after reset, then
// applies requested period/compare settings at period boundaries, optionally
// ramping the compare value by a fixed step once per period.
module pwm_ctrl #(
  parameter logic [15:0] RESET_TOP = 16'hFFFF
) (
  input logic       clk,
  input logic       rst,
  pwm_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    INIT_TOP  = 4'd0,
    INIT_CMP  = 4'd1,
    INIT_CNT  = 4'd2,
    IDLE      = 4'd3,
    WAIT_WRAP = 4'd4,
    LOAD_TOP  = 4'd5,
    LOAD_CMP  = 4'd6,
    LOAD_CNT  = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] sh_top_r;
  logic [15:0] sh_cmp_r;
  logic [15:0] sh_step_r;
  logic        sh_restart_r;
  logic [15:0] cur_cmp_r;
  logic [15:0] next_cmp_s;
  logic [16:0] diff_s;
  logic [15:0] mag_s;
  logic [1:0]  sel_s;
  logic [15:0] d_s;
  logic        ready_s;
  logic        busy_s;
  logic        done_s;
  logic        immediate_s;

  // Restart-style requests skip the period wait and clear the counter at the end.
  assign immediate_s = bus.req_restart && (bus.req_step == 16'd0);

  // Next compare value: one saturating step from cur_cmp toward sh_cmp.
  always_comb begin
    diff_s     = {1'b0, sh_cmp_r} - {1'b0, cur_cmp_r};
    mag_s      = 16'd0;
    next_cmp_s = sh_cmp_r;
    if (sh_step_r == 16'd0) begin
      next_cmp_s = sh_cmp_r;
    end else if (diff_s[16] == 1'b0) begin
      // Target at or above current value: step up, clamp at target.
      mag_s = diff_s[15:0];
      if (mag_s <= sh_step_r) begin
        next_cmp_s = sh_cmp_r;
      end else begin
        next_cmp_s = cur_cmp_r + sh_step_r;
      end
    end else begin
      // Target below current value: step down, clamp at target.
      mag_s = 16'd0 - diff_s[15:0];
      if (mag_s <= sh_step_r) begin
        next_cmp_s = sh_cmp_r;
      end else begin
        next_cmp_s = cur_cmp_r - sh_step_r;
      end
    end
  end

  // Next-state and output decode; every output is forced quiet while in reset.
  always_comb begin
    state_next_s = state_r;
    sel_s        = 2'b00;
    d_s          = 16'd0;
    ready_s      = 1'b0;
    busy_s       = 1'b1;
    done_s       = 1'b0;
    if (rst) begin
      state_next_s = INIT_TOP;
    end else begin
      case (state_r)
        INIT_TOP: begin
          sel_s        = 2'b10;
          d_s          = RESET_TOP;
          state_next_s = INIT_CMP;
        end
        INIT_CMP: begin
          sel_s        = 2'b01;
          state_next_s = INIT_CNT;
        end
        INIT_CNT: begin
          sel_s        = 2'b11;
          state_next_s = IDLE;
        end
        IDLE: begin
          ready_s = 1'b1;
          busy_s  = 1'b0;
          if (bus.req_valid) begin
            state_next_s = immediate_s ? LOAD_TOP : WAIT_WRAP;
          end else begin
            state_next_s = IDLE;
          end
        end
        WAIT_WRAP: begin
          // Leave on the last count of the period so loads land on count 0.
          if (bus.pwm_cnt >= bus.pwm_top) begin
            state_next_s = LOAD_TOP;
          end else begin
            state_next_s = WAIT_WRAP;
          end
        end
        LOAD_TOP: begin
          sel_s        = 2'b10;
          d_s          = sh_top_r;
          state_next_s = LOAD_CMP;
        end
        LOAD_CMP: begin
          sel_s = 2'b01;
          d_s   = next_cmp_s;
          if (next_cmp_s != sh_cmp_r) begin
            state_next_s = WAIT_WRAP;
          end else if (sh_restart_r && (sh_step_r == 16'd0)) begin
            state_next_s = LOAD_CNT;
          end else begin
            state_next_s = DONE;
          end
        end
        LOAD_CNT: begin
          sel_s        = 2'b11;
          state_next_s = DONE;
        end
        DONE: begin
          done_s       = 1'b1;
          state_next_s = IDLE;
        end
        default: begin
          state_next_s = INIT_TOP;
        end
      endcase
    end
  end

  // State register; reset restarts the init sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= INIT_TOP;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request shadow registers and the compare value last written to the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_top_r     <= 16'd0;
      sh_cmp_r     <= 16'd0;
      sh_step_r    <= 16'd0;
      sh_restart_r <= 1'b0;
      cur_cmp_r    <= 16'd0;
    end else begin
      if ((state_r == IDLE) && bus.req_valid) begin
        sh_top_r     <= bus.req_top;
        sh_cmp_r     <= bus.req_cmp;
        sh_step_r    <= bus.req_step;
        sh_restart_r <= bus.req_restart;
      end
      case (state_r)
        INIT_TOP, INIT_CMP, INIT_CNT: cur_cmp_r <= 16'd0;
        LOAD_CMP:                     cur_cmp_r <= next_cmp_s;
        default:                      cur_cmp_r <= cur_cmp_r;
      endcase
    end
  end

  assign bus.pwm_sel   = sel_s;
  assign bus.pwm_d     = d_s;
  assign bus.req_ready = ready_s;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Bench for pwm_ctrl: a PWM timer model reacts to the command bus, a
// reference model pushes the expected command/done sequence per request,
// and a negedge monitor pops and compares every non-idle bus cycle.
module tb_pwm_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_ctrl_if bus ();

  pwm_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- PWM timer model ----------------
  logic [15:0] m_cnt, m_top, m_cmp;
  logic        preset_en;
  logic [15:0] preset_val;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 16'd0;
      m_top <= 16'hFFFF;
      m_cmp <= 16'd0;
    end else if (preset_en) begin
      m_cnt <= preset_val;
    end else if (bus.pwm_sel == 2'b11) begin
      m_cnt <= bus.pwm_d;
    end else begin
      m_cnt <= (m_cnt >= m_top) ? 16'd0 : m_cnt + 16'd1;
      if (bus.pwm_sel == 2'b10) m_top <= bus.pwm_d;
      if (bus.pwm_sel == 2'b01) m_cmp <= bus.pwm_d;
    end
  end

  assign bus.pwm_cnt = m_cnt;
  assign bus.pwm_top = m_top;

  // ---------------- checking ----------------
  int checks = 0;
  int passes = 0;
  int cmp_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] d;
    logic        done;
    logic        chk_cnt;
    logic [15:0] exp_cnt;
  } ev_t;

  ev_t sbq[$];
  ev_t mon_ev;

  typedef struct {
    logic [15:0] top;
    logic [15:0] cmp;
    logic [15:0] step;
    logic        restart;
    int          at_cnt;
    int          exp_writes;
    logic [15:0] exp_last;
  } req_t;

  req_t tbl[11];

  // reference state: compare value last applied and timer top before a request
  int model_cur = 0;
  int model_top = 65535;

  function automatic int ref_step(input int c, input int target, input int s);
    if (s == 0 || c == target) return target;
    if (target > c) return (c + s > target) ? target : c + s;
    return (c - s < target) ? target : c - s;
  endfunction

  task automatic push_req(input req_t r);
    int c;
    int nc;
    int old_top;
    if (r.restart && r.step == 16'd0) begin
      sbq.push_back('{2'b10, r.top, 1'b0, 1'b0, 16'd0});
      sbq.push_back('{2'b01, r.cmp, 1'b0, 1'b0, 16'd0});
      sbq.push_back('{2'b11, 16'd0, 1'b0, 1'b0, 16'd0});
      model_cur = int'(r.cmp);
    end else begin
      c = model_cur;
      old_top = model_top;
      do begin
        nc = ref_step(c, int'(r.cmp), int'(r.step));
        sbq.push_back('{2'b10, r.top, 1'b0, 1'b1, 16'd0});
        sbq.push_back('{2'b01, 16'(nc), 1'b0, 1'b1, (old_top == 0) ? 16'd0 : 16'd1});
        old_top = int'(r.top);
        c = nc;
      end while (c != int'(r.cmp));
      model_cur = c;
    end
    sbq.push_back('{2'b00, 16'd0, 1'b1, 1'b0, 16'd0});
    model_top = int'(r.top);
  endtask

  // Monitor: every command or done cycle must match the next expected event.
  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.pwm_sel != 2'b00 || bus.done === 1'b1)) begin
      if (bus.pwm_sel == 2'b01) cmp_writes++;
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event: got sel=%b d=%h done=%b, required no event",
                 bus.pwm_sel, bus.pwm_d, bus.done);
      end else begin
        mon_ev = sbq.pop_front();
        check("ev_sel", 32'(bus.pwm_sel), 32'(mon_ev.sel));
        check("ev_d", 32'(bus.pwm_d), 32'(mon_ev.d));
        check("ev_done", 32'(bus.done), 32'(mon_ev.done));
        if (mon_ev.chk_cnt) check("ev_cnt_align", 32'(m_cnt), 32'(mon_ev.exp_cnt));
      end
    end
  end

  task automatic push_init();
    sbq.push_back('{2'b10, 16'hFFFF, 1'b0, 1'b0, 16'd0});
    sbq.push_back('{2'b01, 16'd0, 1'b0, 1'b0, 16'd0});
    sbq.push_back('{2'b11, 16'd0, 1'b0, 1'b0, 16'd0});
    model_cur = 0;
    model_top = 65535;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!(sbq.size() == 0 && bus.req_ready === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      $display("FAIL %s_timeout: got %0d pending events, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic drive(input req_t r);
    bus.req_top     = r.top;
    bus.req_cmp     = r.cmp;
    bus.req_step    = r.step;
    bus.req_restart = r.restart;
  endtask

  task automatic do_req(input req_t r);
    int n = 0;
    @(negedge clk);
    while (!(bus.req_ready === 1'b1 && (r.at_cnt < 0 || int'(bus.pwm_cnt) == r.at_cnt)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      $display("FAIL req_accept_timeout: got ready=%b cnt=%0d", bus.req_ready, bus.pwm_cnt);
    end
    drive(r);
    bus.req_valid = 1'b1;
    push_req(r);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_entry(input int i);
    cmp_writes = 0;
    do_req(tbl[i]);
    wait_idle($sformatf("entry%0d", i));
    check($sformatf("entry%0d_writes", i), 32'(cmp_writes), 32'(tbl[i].exp_writes));
    check($sformatf("entry%0d_cmp", i), 32'(m_cmp), 32'(tbl[i].exp_last));
    check($sformatf("entry%0d_top", i), 32'(m_top), 32'(tbl[i].top));
  endtask

  req_t ra, rb;
  int   hi_cnt;
  bit   saw_done;

  initial begin
    //            top        cmp        step       rst   at   wr  last
    tbl[0]  = '{16'd9,    16'd3,     16'd0,     1'b1, -1,  1, 16'd3};
    tbl[1]  = '{16'd99,   16'd50,    16'd0,     1'b1, -1,  1, 16'd50};
    tbl[2]  = '{16'd49,   16'd10,    16'd0,     1'b0, 20,  1, 16'd10};
    tbl[3]  = '{16'd49,   16'd0,     16'd0,     1'b0, -1,  1, 16'd0};
    tbl[4]  = '{16'd49,   16'd10,    16'd4,     1'b1, -1,  3, 16'd10};
    tbl[5]  = '{16'd0,    16'd5,     16'd0,     1'b1, -1,  1, 16'd5};
    tbl[6]  = '{16'd0,    16'd5,     16'd3,     1'b0, -1,  1, 16'd5};
    tbl[7]  = '{16'd0,    16'hFFFF,  16'hFFF0,  1'b0, -1,  2, 16'hFFFF};
    tbl[8]  = '{16'd0,    16'd0,     16'h8000,  1'b0, -1,  2, 16'd0};
    tbl[9]  = '{16'd9,    16'd7,     16'd0,     1'b0, -1,  1, 16'd7};
    tbl[10] = '{16'd9,    16'd4,     16'd4,     1'b0, -1,  1, 16'd4};

    rst = 1'b1;
    preset_en = 1'b0;
    preset_val = 16'd0;
    bus.req_valid = 1'b0;
    drive(tbl[0]);

    // reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_sel", 32'(bus.pwm_sel), 32'd0);
    check("rst_d", 32'(bus.pwm_d), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push_init();
    repeat (4) @(negedge clk);
    check("init_ready_cycle4", 32'(bus.req_ready), 32'd1);
    check("init_busy_cycle4", 32'(bus.busy), 32'd0);
    check("init_queue_empty", 32'(sbq.size()), 32'd0);

    for (int i = 0; i <= 4; i++) run_entry(i);

    // ramp down with a second request held against backpressure
    ra = '{16'd49, 16'd0, 16'd7, 1'b0, -1, 2, 16'd0};
    rb = '{16'd39, 16'd20, 16'd0, 1'b0, -1, 1, 16'd20};
    cmp_writes = 0;
    do_req(ra);
    drive(rb);
    bus.req_valid = 1'b1;
    hi_cnt = 0;
    saw_done = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (saw_done) break;
      if (bus.req_ready === 1'b1) hi_cnt++;
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    check("bp_saw_done", 32'(saw_done), 32'd1);
    check("bp_ready_low_cycles", 32'(hi_cnt), 32'd0);
    check("bp_ready_after_done", 32'(bus.req_ready), 32'd1);
    push_req(rb);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_idle("bp");
    check("bp_writes", 32'(cmp_writes), 32'd3);
    check("bp_cmp", 32'(m_cmp), 32'd20);
    check("bp_top", 32'(m_top), 32'd39);

    for (int i = 5; i <= 9; i++) run_entry(i);

    // reset pulse between ramp steps
    cmp_writes = 0;
    do_req('{16'd9, 16'd40, 16'd5, 1'b0, -1, 0, 16'd0});
    for (int n = 0; n < 200 && cmp_writes == 0; n++) @(negedge clk);
    check("mid_first_write", 32'(cmp_writes), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd1);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push_init();
    wait_idle("mid_init");
    // skip most of the reset-length period
    preset_val = 16'hFFF0;
    preset_en = 1'b1;
    @(negedge clk);
    preset_en = 1'b0;
    run_entry(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
